// File: rtl/conv_window_addr_gen_pkg.sv
// ---------------------------------------------------------------------------
// conv_window_addr_gen_pkg
// Shared accelerator definitions for the convolution window address
// generator: FSM state encoding and the supported kernel-edge range.
// ---------------------------------------------------------------------------
package conv_window_addr_gen_pkg;

    // Scan controller states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } wag_state_t;

    // Supported square-kernel edge lengths in pixels
    localparam int KSIZE_MIN = 1;
    localparam int KSIZE_MAX = 15;

endpackage

// File: rtl/conv_window_addr_gen_axis_counter.sv
// ---------------------------------------------------------------------------
// wag_axis_counter
// One scan axis (kc, kr, ocol or orow) of the window address generator.
// Counts 0..limit, wrapping back to 0 when enabled at the terminal value.
//
// Ports
//   COUNTER_OFFSET_Clk : clock, rising edge
//   COUNTER_OFFSET_Clr : asynchronous active-low clear
//   clear              : synchronous restart to 0 (has priority over enable)
//   enable             : advance by one position
//   limit              : terminal value (last position of the axis)
//   count              : current position
//   at_term            : count equals limit
// ---------------------------------------------------------------------------
module wag_axis_counter #(
    parameter int BITWIDTH = 10
) (
    input  logic                COUNTER_OFFSET_Clk,
    input  logic                COUNTER_OFFSET_Clr,
    input  logic                clear,
    input  logic                enable,
    input  logic [BITWIDTH-1:0] limit,
    output logic [BITWIDTH-1:0] count,
    output logic                at_term
);

    assign at_term = (count == limit);

    // Wrap counter: a restart request wins, otherwise step and wrap at limit
    always_ff @(posedge COUNTER_OFFSET_Clk or negedge COUNTER_OFFSET_Clr) begin
        if (!COUNTER_OFFSET_Clr) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_term ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/conv_window_addr_gen.sv
// ---------------------------------------------------------------------------
// conv_window_addr_gen
// Generates pixel read addresses for a KSIZE x KSIZE stride-1 convolution
// over a W x H feature map: output positions in raster order, and within
// each window kernel rows outer, kernel columns inner.
//
// Ports
//   COUNTER_OFFSET_Clk : clock, rising edge
//   COUNTER_OFFSET_Clr : asynchronous active-low reset
//   WAG_Start          : one-cycle scan request (ignored while busy)
//   WAG_Img_Width/Height/Base_Addr : scan geometry, latched at start
//   WAG_Addr_Ready     : downstream accepts WAG_Addr this cycle
//   WAG_Addr / WAG_Addr_Valid : address stream
//   WAG_Win_Last       : address is the last one of its window
//   WAG_Busy           : scan in progress (RUN or FINISH)
//   WAG_Done           : one-cycle pulse at scan end
//   WAG_Err            : sticky, image smaller than kernel
// ---------------------------------------------------------------------------
module conv_window_addr_gen
    import conv_window_addr_gen_pkg::*;
#(
    parameter int BITWIDTH = 10,
    parameter int KSIZE    = 3
) (
    input  logic                COUNTER_OFFSET_Clk,
    input  logic                COUNTER_OFFSET_Clr,
    input  logic                WAG_Start,
    input  logic [BITWIDTH-1:0] WAG_Img_Width,
    input  logic [BITWIDTH-1:0] WAG_Img_Height,
    input  logic [BITWIDTH-1:0] WAG_Base_Addr,
    input  logic                WAG_Addr_Ready,
    output logic [BITWIDTH-1:0] WAG_Addr,
    output logic                WAG_Addr_Valid,
    output logic                WAG_Win_Last,
    output logic                WAG_Busy,
    output logic                WAG_Done,
    output logic                WAG_Err
);

    // An out-of-range kernel parameter is clamped into the supported range
    localparam int KSIZE_EFF = (KSIZE < KSIZE_MIN) ? KSIZE_MIN :
                               (KSIZE > KSIZE_MAX) ? KSIZE_MAX : KSIZE;
    localparam logic [BITWIDTH-1:0] K_EDGE = BITWIDTH'(KSIZE_EFF);
    localparam logic [BITWIDTH-1:0] K_LAST = BITWIDTH'(KSIZE_EFF - 1);

    wag_state_t state, next_state;

    logic [BITWIDTH-1:0] img_width, col_limit, row_limit;
    logic [BITWIDTH-1:0] win_row_base, line_base;
    logic [BITWIDTH-1:0] kc_count, kr_count, ocol_count, orow_count;
    logic                kc_term, kr_term, ocol_term, orow_term;
    logic                size_bad, start_seen, start_legal;
    logic                accept, win_end, row_end, scan_end;
    logic                unused_idx;

    assign size_bad    = (WAG_Img_Width < K_EDGE) || (WAG_Img_Height < K_EDGE);
    assign start_seen  = (state == IDLE) && WAG_Start;
    assign start_legal = start_seen && !size_bad;
    assign accept      = (state == RUN) && WAG_Addr_Ready;
    assign win_end     = kc_term && kr_term;
    assign row_end     = win_end && ocol_term;
    assign scan_end    = row_end && orow_term;

    // Row and kernel-row indices live in line_base; only their terminal flags matter
    assign unused_idx  = ^{kr_count, orow_count};

    wag_axis_counter #(.BITWIDTH(BITWIDTH)) u_kc (
        .COUNTER_OFFSET_Clk (COUNTER_OFFSET_Clk),
        .COUNTER_OFFSET_Clr (COUNTER_OFFSET_Clr),
        .clear              (start_legal),
        .enable             (accept),
        .limit              (K_LAST),
        .count              (kc_count),
        .at_term            (kc_term)
    );

    wag_axis_counter #(.BITWIDTH(BITWIDTH)) u_kr (
        .COUNTER_OFFSET_Clk (COUNTER_OFFSET_Clk),
        .COUNTER_OFFSET_Clr (COUNTER_OFFSET_Clr),
        .clear              (start_legal),
        .enable             (accept && kc_term),
        .limit              (K_LAST),
        .count              (kr_count),
        .at_term            (kr_term)
    );

    wag_axis_counter #(.BITWIDTH(BITWIDTH)) u_ocol (
        .COUNTER_OFFSET_Clk (COUNTER_OFFSET_Clk),
        .COUNTER_OFFSET_Clr (COUNTER_OFFSET_Clr),
        .clear              (start_legal),
        .enable             (accept && win_end),
        .limit              (col_limit),
        .count              (ocol_count),
        .at_term            (ocol_term)
    );

    wag_axis_counter #(.BITWIDTH(BITWIDTH)) u_orow (
        .COUNTER_OFFSET_Clk (COUNTER_OFFSET_Clk),
        .COUNTER_OFFSET_Clr (COUNTER_OFFSET_Clr),
        .clear              (start_legal),
        .enable             (accept && row_end),
        .limit              (row_limit),
        .count              (orow_count),
        .at_term            (orow_term)
    );

    // State register
    always_ff @(posedge COUNTER_OFFSET_Clk or negedge COUNTER_OFFSET_Clr) begin
        if (!COUNTER_OFFSET_Clr) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; an undersized image skips straight to FINISH
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (WAG_Start) next_state = size_bad ? FINISH : RUN;
            RUN:     if (accept && scan_end) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Geometry latch and line-base tracking. line_base always holds
    // base + (orow+kr)*W, built with adds of W as kernel rows and output rows
    // advance; win_row_base holds base + orow*W to rewind at each new window.
    always_ff @(posedge COUNTER_OFFSET_Clk or negedge COUNTER_OFFSET_Clr) begin
        if (!COUNTER_OFFSET_Clr) begin
            img_width    <= '0;
            col_limit    <= '0;
            row_limit    <= '0;
            win_row_base <= '0;
            line_base    <= '0;
        end else if (start_legal) begin
            img_width    <= WAG_Img_Width;
            col_limit    <= WAG_Img_Width - K_EDGE;
            row_limit    <= WAG_Img_Height - K_EDGE;
            win_row_base <= WAG_Base_Addr;
            line_base    <= WAG_Base_Addr;
        end else if (accept) begin
            if (win_end) begin
                if (ocol_term) begin
                    win_row_base <= win_row_base + img_width;
                    line_base    <= win_row_base + img_width;
                end else begin
                    line_base    <= win_row_base;
                end
            end else if (kc_term) begin
                line_base <= line_base + img_width;
            end
        end
    end

    // Sticky size error, re-evaluated on every start seen in IDLE
    always_ff @(posedge COUNTER_OFFSET_Clk or negedge COUNTER_OFFSET_Clr) begin
        if (!COUNTER_OFFSET_Clr) begin
            WAG_Err <= 1'b0;
        end else if (start_seen) begin
            WAG_Err <= size_bad;
        end
    end

    assign WAG_Addr       = line_base + ocol_count + kc_count;
    assign WAG_Addr_Valid = (state == RUN);
    assign WAG_Win_Last   = (state == RUN) && win_end;
    assign WAG_Busy       = (state == RUN) || (state == FINISH);
    assign WAG_Done       = (state == FINISH);

endmodule

// File: tb/tb_conv_window_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_window_addr_gen
// Directed self-checking bench for conv_window_addr_gen (BITWIDTH=10, KSIZE=3).
// ---------------------------------------------------------------------------
module tb_conv_window_addr_gen;

    localparam int K = 3;

    logic       COUNTER_OFFSET_Clk = 1'b0;
    logic       COUNTER_OFFSET_Clr = 1'b0;
    logic       WAG_Start          = 1'b0;
    logic [9:0] WAG_Img_Width      = '0;
    logic [9:0] WAG_Img_Height     = '0;
    logic [9:0] WAG_Base_Addr      = '0;
    logic       WAG_Addr_Ready     = 1'b0;
    logic [9:0] WAG_Addr;
    logic       WAG_Addr_Valid;
    logic       WAG_Win_Last;
    logic       WAG_Busy;
    logic       WAG_Done;
    logic       WAG_Err;

    int         errors = 0;
    int         checks = 0;
    int         doneCount = 0;
    int         lastCount = 0;
    logic [9:0] captured[$];

    conv_window_addr_gen dut (
        .COUNTER_OFFSET_Clk (COUNTER_OFFSET_Clk),
        .COUNTER_OFFSET_Clr (COUNTER_OFFSET_Clr),
        .WAG_Start          (WAG_Start),
        .WAG_Img_Width      (WAG_Img_Width),
        .WAG_Img_Height     (WAG_Img_Height),
        .WAG_Base_Addr      (WAG_Base_Addr),
        .WAG_Addr_Ready     (WAG_Addr_Ready),
        .WAG_Addr           (WAG_Addr),
        .WAG_Addr_Valid     (WAG_Addr_Valid),
        .WAG_Win_Last       (WAG_Win_Last),
        .WAG_Busy           (WAG_Busy),
        .WAG_Done           (WAG_Done),
        .WAG_Err            (WAG_Err)
    );

    // 10 ns clock
    always #5 COUNTER_OFFSET_Clk = ~COUNTER_OFFSET_Clk;

    // Count Done pulses in the middle of each cycle
    always @(negedge COUNTER_OFFSET_Clk) begin
        if (WAG_Done) doneCount++;
    end

    // Single comparison point for the whole bench
    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present geometry and pulse Start for one clock; returns 1 ns after that edge
    task automatic applyStimulus(input int base, input int w, input int h);
        WAG_Base_Addr  = 10'(base);
        WAG_Img_Width  = 10'(w);
        WAG_Img_Height = 10'(h);
        WAG_Start      = 1'b1;
        @(posedge COUNTER_OFFSET_Clk);
        #1;
        WAG_Start      = 1'b0;
    endtask

    // Full scan against a reference list built from the address formula.
    // stall selects the 1,0,0,1 Ready pattern; poke pulses Start (with other
    // geometry) mid-scan, which must be ignored.
    task automatic runScan(input int base, input int w, input int h,
                           input bit stall, input bit poke, input string tag);
        logic [9:0] expq[$];
        bit         pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int         n   = 0;
        int         cyc = 0;
        for (int orow = 0; orow <= h - K; orow++)
            for (int ocol = 0; ocol <= w - K; ocol++)
                for (int kr = 0; kr < K; kr++)
                    for (int kc = 0; kc < K; kc++)
                        expq.push_back(10'(base + (orow + kr) * w + ocol + kc));
        captured.delete();
        lastCount = 0;
        doneCount = 0;
        applyStimulus(base, w, h);
        checkOutput({tag, "_err_clear"}, int'(WAG_Err), 0);
        while (n < expq.size() && cyc < 2000) begin
            WAG_Addr_Ready = stall ? pat[cyc % 4] : 1'b1;
            if (poke && cyc == 3) begin
                WAG_Start      = 1'b1;
                WAG_Base_Addr  = 10'd0;
                WAG_Img_Width  = 10'd7;
                WAG_Img_Height = 10'd7;
            end
            checkOutput({tag, "_valid"}, int'(WAG_Addr_Valid), 1);
            checkOutput({tag, "_addr"}, int'(WAG_Addr), int'(expq[n]));
            checkOutput({tag, "_winlast"}, int'(WAG_Win_Last), int'((n % (K * K)) == K * K - 1));
            if (WAG_Addr_Ready) begin
                captured.push_back(WAG_Addr);
                if (WAG_Win_Last) lastCount++;
                n++;
            end
            @(posedge COUNTER_OFFSET_Clk);
            #1;
            WAG_Start = 1'b0;
            cyc++;
        end
        checkOutput({tag, "_no_timeout"}, n, expq.size());
        checkOutput({tag, "_done_pulse"}, int'(WAG_Done), 1);
        checkOutput({tag, "_valid_off"}, int'(WAG_Addr_Valid), 0);
        @(posedge COUNTER_OFFSET_Clk);
        #1;
        checkOutput({tag, "_done_low"}, int'(WAG_Done), 0);
        checkOutput({tag, "_busy_low"}, int'(WAG_Busy), 0);
        checkOutput({tag, "_done_count"}, doneCount, 1);
        checkOutput({tag, "_winlast_count"}, lastCount, (w - K + 1) * (h - K + 1));
    endtask

    initial begin
        int firstWin[9] = '{100, 101, 102, 105, 106, 107, 110, 111, 112};
        int wrapSeq[9]  = '{1020, 1021, 1022, 1023, 0, 1, 2, 3, 4};

        // Reset state
        repeat (2) @(posedge COUNTER_OFFSET_Clk);
        #1;
        checkOutput("rst_addr", int'(WAG_Addr), 0);
        checkOutput("rst_valid", int'(WAG_Addr_Valid), 0);
        checkOutput("rst_winlast", int'(WAG_Win_Last), 0);
        checkOutput("rst_busy", int'(WAG_Busy), 0);
        checkOutput("rst_done", int'(WAG_Done), 0);
        checkOutput("rst_err", int'(WAG_Err), 0);
        COUNTER_OFFSET_Clr = 1'b1;
        @(posedge COUNTER_OFFSET_Clk);
        #1;

        // Nominal 5x5 scan at base 100
        runScan(100, 5, 5, 1'b0, 1'b0, "nominal");
        checkOutput("nominal_count", captured.size(), 81);
        for (int i = 0; i < 9; i++)
            checkOutput("nominal_first_window", int'(captured[i]), firstWin[i]);
        checkOutput("nominal_last_addr", int'(captured[captured.size() - 1]), 124);

        // Same scan under 1,0,0,1 backpressure
        runScan(100, 5, 5, 1'b1, 1'b0, "stall");
        checkOutput("stall_count", captured.size(), 81);
        checkOutput("stall_last_addr", int'(captured[captured.size() - 1]), 124);

        // Undersized image: error, no addresses, single Done
        doneCount = 0;
        applyStimulus(100, 2, 5);
        checkOutput("illegal_valid", int'(WAG_Addr_Valid), 0);
        checkOutput("illegal_err", int'(WAG_Err), 1);
        checkOutput("illegal_done", int'(WAG_Done), 1);
        checkOutput("illegal_busy", int'(WAG_Busy), 1);
        @(posedge COUNTER_OFFSET_Clk);
        #1;
        checkOutput("illegal_valid2", int'(WAG_Addr_Valid), 0);
        checkOutput("illegal_done_low", int'(WAG_Done), 0);
        checkOutput("illegal_err_sticky", int'(WAG_Err), 1);
        checkOutput("illegal_done_count", doneCount, 1);

        // Legal start clears Err; address wrap; Start while busy ignored
        runScan(1020, 3, 3, 1'b0, 1'b1, "wrap");
        checkOutput("wrap_count", captured.size(), 9);
        for (int i = 0; i < 9; i++)
            checkOutput("wrap_seq", int'(captured[i]), wrapSeq[i]);

        // Reset after 20 accepts
        doneCount = 0;
        applyStimulus(100, 5, 5);
        WAG_Addr_Ready = 1'b1;
        repeat (20) @(posedge COUNTER_OFFSET_Clk);
        #2;
        COUNTER_OFFSET_Clr = 1'b0;
        #1;
        checkOutput("midrst_addr", int'(WAG_Addr), 0);
        checkOutput("midrst_valid", int'(WAG_Addr_Valid), 0);
        checkOutput("midrst_winlast", int'(WAG_Win_Last), 0);
        checkOutput("midrst_busy", int'(WAG_Busy), 0);
        checkOutput("midrst_done", int'(WAG_Done), 0);
        checkOutput("midrst_err", int'(WAG_Err), 0);
        repeat (2) @(posedge COUNTER_OFFSET_Clk);
        #1;
        COUNTER_OFFSET_Clr = 1'b1;
        checkOutput("midrst_no_done", doneCount, 0);
        @(posedge COUNTER_OFFSET_Clk);
        #1;
        runScan(100, 5, 5, 1'b0, 1'b0, "restart");
        checkOutput("restart_first", int'(captured[0]), 100);

        // Non-square geometry
        runScan(7, 6, 4, 1'b1, 1'b0, "rect");
        checkOutput("rect_count", captured.size(), 72);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/conv_window_addr_gen.md
CONV_WINDOW_ADDR_GEN -- requirements
Module: conv_window_addr_gen

Interface
REQ-001 SHALL have parameter BITWIDTH, default 10, setting the width of the address and dimension fields.
REQ-002 SHALL have parameter KSIZE, default 3, setting the square kernel edge in pixels (legal range 1..15).
REQ-003 SHALL have port COUNTER_OFFSET_Clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 SHALL have port COUNTER_OFFSET_Clr, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port WAG_Start, input, 1 bit: single-cycle request to begin one feature-map scan.
REQ-006 SHALL have port WAG_Img_Width, input, BITWIDTH bits: image width W in pixels.
REQ-007 SHALL have port WAG_Img_Height, input, BITWIDTH bits: image height H in pixels.
REQ-008 SHALL have port WAG_Base_Addr, input, BITWIDTH bits: memory address of pixel (0,0).
REQ-009 SHALL have port WAG_Addr_Ready, input, 1 bit: downstream image memory accepts the address.
REQ-010 SHALL have port WAG_Addr, output, BITWIDTH bits: pixel read address.
REQ-011 SHALL have port WAG_Addr_Valid, output, 1 bit: WAG_Addr is valid.
REQ-012 SHALL have port WAG_Win_Last, output, 1 bit: current address is the last of its KSIZE x KSIZE window.
REQ-013 SHALL have port WAG_Busy, output, 1 bit: a scan is in progress.
REQ-014 SHALL have port WAG_Done, output, 1 bit: one-cycle pulse at scan end.
REQ-015 SHALL have port WAG_Err, output, 1 bit: sticky flag set when W<KSIZE or H<KSIZE.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, FINISH; IDLE->RUN on WAG_Start with legal dimensions; RUN->FINISH on acceptance of the final address; FINISH->IDLE unconditionally after one cycle.
REQ-017 SHALL latch W, H and base address on the accepted WAG_Start; later input changes have no effect until the next scan.
REQ-018 SHALL ignore WAG_Start while WAG_Busy=1.
REQ-019 SHALL, on WAG_Start with W<KSIZE or H<KSIZE, go IDLE->FINISH, set WAG_Err, emit no addresses, and pulse WAG_Done one cycle later.
REQ-020 SHALL clear WAG_Err on the next accepted legal WAG_Start.
REQ-021 SHALL scan output positions in raster order: orow 0..H-KSIZE outer, ocol 0..W-KSIZE inner (stride 1).
REQ-022 SHALL, within each window, emit kr 0..KSIZE-1 outer and kc 0..KSIZE-1 inner.
REQ-023 SHALL set WAG_Addr = base + (orow+kr)*W + ocol + kc, computed modulo 2^BITWIDTH.
REQ-024 SHALL build the (orow+kr)*W term incrementally with registered adds; no multiplier is permitted.
REQ-025 SHALL present the first address in the cycle after the accepted WAG_Start, giving 1-cycle latency.
REQ-026 SHALL treat an address as accepted when WAG_Addr_Valid=1 and WAG_Addr_Ready=1 in the same cycle; the generator then advances by one address.
REQ-027 SHALL hold WAG_Addr, WAG_Win_Last and WAG_Addr_Valid stable while WAG_Addr_Valid=1 and WAG_Addr_Ready=0.
REQ-028 SHALL sustain one accepted address per cycle while WAG_Addr_Ready=1, with no bubbles at window or row boundaries.
REQ-029 SHALL assert WAG_Win_Last exactly when kr=kc=KSIZE-1.
REQ-030 SHALL assert WAG_Busy in RUN and FINISH only.
REQ-031 SHALL pulse WAG_Done for exactly one cycle, in FINISH.

Reset
REQ-032 SHALL, on COUNTER_OFFSET_Clr=0, immediately force state IDLE, all counters 0, WAG_Addr=0, and WAG_Addr_Valid, WAG_Win_Last, WAG_Busy, WAG_Done and WAG_Err all 0.
REQ-033 SHALL abandon any scan on reset mid-operation without a WAG_Done pulse; the next WAG_Start after reset release restarts from position (0,0).

Structure
REQ-034 SHALL place the FSM state encoding (IDLE, RUN, FINISH) and the KSIZE legal-range constants in the shared accelerator package.
REQ-035 SHALL instantiate one sub-module, wag_axis_counter, four times (kc, kr, ocol, orow); it is a wrap counter with enable, terminal-count flag and asynchronous active-low clear.

Verification
REQ-036 SHALL cover nominal scan: W=5, H=5, KSIZE=3, base=100, Ready=1 -> first window 100,101,102,105,106,107,110,111,112; 81 addresses total; last address 124; WAG_Win_Last asserted 9 times; WAG_Done one cycle after the last accept.
REQ-037 SHALL cover backpressure: Ready toggled 1,0,0,1 -> the address is held unchanged through the stall; sequence identical to REQ-036; no address duplicated or dropped.
REQ-038 SHALL cover illegal size: W=2, H=5 -> no WAG_Addr_Valid; WAG_Err=1; WAG_Done pulses once; a following legal start clears WAG_Err.
REQ-039 SHALL cover reset mid-scan: Clr low after 20 accepts -> all outputs 0 asynchronously; no WAG_Done; a restart emits base+0 first.
REQ-040 SHALL cover wrap and start-while-busy: base=1020, W=H=3, BITWIDTH=10 -> addresses wrap, 1020..1023 then 0..4; WAG_Start pulsed during RUN -> ignored.
